dmem_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port data memory (8-bit x 256, combinational read, write on clock edge) between `N` requesters, such as the core load/store unit and a program/data loader. Each cycle it grants at most one requester, drives the memory's write-enable, address and write-data lines, and returns registered read data with a one-cycle `rvalid` pulse. A bounded lock lets a requester hold the memory for back-to-back accesses.

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter_rr_pick.sv | 33 +++
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Provides the FSM state encoding, the default widths and a one-hot helper.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_W       = 8;
    localparam int DEF_A       = 8;
    localparam int DEF_MAXLOCK = 4;

    // One-hot decode of a requester index (up to 8 requesters).
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request strictly after i_last,
// wrapping modulo N, returned both one-hot and as an index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_pos;
    logic          w_hit;

    // Scan N positions starting just after the previous winner; the first hit wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        w_hit   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            w_pos        = IW'((int'(i_last) + k) % N);
            w_hit        = i_req[w_pos] & ~o_valid;
            o_gnt[w_pos] = w_hit;
            o_idx        = w_hit ? w_pos : o_idx;
            o_valid      = o_valid | w_hit;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for a single-port data memory with a bounded lock,
// same-cycle grant and registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N       = 2,
    parameter int W       = DEF_W,
    parameter int A       = DEF_A,
    parameter int MAXLOCK = DEF_MAXLOCK
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   we,
    input  logic [N-1:0]   lock,
    input  logic [N*A-1:0] addr,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rvalid,
    output logic [W-1:0]   rdata,
    output logic           mem_write_en,
    output logic [A-1:0]   mem_addr,
    output logic [W-1:0]   mem_data_in,
    input  logic [W-1:0]   mem_data_out
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (($clog2(MAXLOCK) + 1) < 3) ? 3 : ($clog2(MAXLOCK) + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXLOCK);
    localparam logic [CW-1:0] CNT_SAT = '1;

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [IW-1:0] r_last;
    logic [IW-1:0] w_last_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_owner_nxt;
    logic [CW-1:0] r_lock_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;
    logic [N-1:0]  r_rvalid;
    logic [W-1:0]  r_rdata;

    logic [N-1:0]  w_pick_gnt;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic [N-1:0]  w_owner_oh;
    logic [N-1:0]  w_sel_gnt;
    logic [IW-1:0] w_sel_idx;
    logic          w_sel_valid;
    logic          w_go;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req   (req),
        .i_last  (r_last),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_owner_oh = N'(onehot8(3'(r_owner)));

    // Grant source: round-robin picker in ARB, the held owner in LOCKED.
    always_comb begin
        w_sel_gnt   = '0;
        w_sel_idx   = '0;
        w_sel_valid = 1'b0;
        case (r_state)
            ARB: begin
                w_sel_gnt   = w_pick_gnt;
                w_sel_idx   = w_pick_idx;
                w_sel_valid = w_pick_valid;
            end
            LOCKED: begin
                w_sel_idx   = r_owner;
                w_sel_valid = req[r_owner];
                w_sel_gnt   = req[r_owner] ? w_owner_oh : '0;
            end
            default: begin
                w_sel_valid = 1'b0;
            end
        endcase
    end

    // Reset gates the memory side asynchronously so no write lands at a reset edge.
    assign w_go         = reset & w_sel_valid;
    assign gnt          = w_go ? w_sel_gnt : '0;
    assign mem_write_en = w_go & we[w_sel_idx];
    assign mem_addr     = w_go ? addr[w_sel_idx*A +: A] : '0;
    assign mem_data_in  = w_go ? wdata[w_sel_idx*W +: W] : '0;

    // Next state: lock entry, saturating hold count and the three release causes.
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_lock_cnt;
        w_cnt_inc   = (r_lock_cnt == CNT_SAT) ? r_lock_cnt : (r_lock_cnt + CW'(1'b1));
        case (r_state)
            ARB: begin
                if (w_sel_valid) begin
                    w_last_nxt = w_sel_idx;
                    if (lock[w_sel_idx] && (MAXLOCK > 1)) begin
                        w_state_nxt = LOCKED;
                        w_owner_nxt = w_sel_idx;
                        w_cnt_nxt   = CW'(1'b1);
                    end else begin
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            LOCKED: begin
                if (w_sel_valid) begin
                    w_last_nxt = r_owner;
                    if (!lock[r_owner] || (w_cnt_inc >= CNT_MAX)) begin
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ARB;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Arbitration state register; requester 0 wins first after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ARB;
            r_last     <= IW'(N - 1);
            r_owner    <= '0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_owner    <= w_owner_nxt;
            r_lock_cnt <= w_cnt_nxt;
        end
    end

    // Read return: capture memory data and pulse rvalid for the granted reader.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else if (w_sel_valid && !we[w_sel_idx]) begin
            r_rvalid <= w_sel_gnt;
            r_rdata  <= mem_data_out;
        end else begin
            r_rvalid <= '0;
        end
    end

    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural 8x256 memory: vector table for
// arbitration/access checks, scoreboard queue for read returns, hand sequences for reset.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  lock;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  gnt;
    logic [1:0]  rvalid;
    logic [7:0]  rdata;
    logic        mem_write_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;

    logic [7:0]  mem   [0:255];
    logic [7:0]  model [0:255];
    logic [7:0]  exp_hold;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] req;
        logic [1:0] we;
        logic [1:0] lock;
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] gnt;
    } vec_t;

    typedef struct packed {
        logic [1:0] rv;
        logic [7:0] rd;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sbq[$];

    dmem_arbiter #(
        .N       (2),
        .W       (8),
        .A       (8),
        .MAXLOCK (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .we           (we),
        .lock         (lock),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .mem_write_en (mem_write_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_data_in;
    end
    assign mem_data_out = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addv(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                        input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] g);
        vec_t v;
        v.req = r; v.we = w; v.lock = l;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.gnt = g;
        vecs.push_back(v);
    endtask

    // Drive one cycle, check grant and memory side, then check the read return.
    task automatic apply(input vec_t v, input int id);
        logic       granted;
        logic       gi;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       ew;
        rsp_t       r;
        @(negedge clk);
        req   = v.req;
        we    = v.we;
        lock  = v.lock;
        addr  = {v.a1, v.a0};
        wdata = {v.d1, v.d0};
        #1;
        granted = |v.gnt;
        gi      = v.gnt[1];
        ea      = granted ? (gi ? v.a1 : v.a0) : 8'h00;
        ed      = granted ? (gi ? v.d1 : v.d0) : 8'h00;
        ew      = granted & v.we[gi];
        chk($sformatf("gnt[v%0d]", id), 32'(gnt), 32'(v.gnt));
        chk($sformatf("mem_write_en[v%0d]", id), 32'(mem_write_en), 32'(ew));
        chk($sformatf("mem_addr[v%0d]", id), 32'(mem_addr), 32'(ea));
        chk($sformatf("mem_data_in[v%0d]", id), 32'(mem_data_in), 32'(ed));
        if (granted && !ew) begin
            exp_hold = model[ea];
            sbq.push_back({v.gnt, model[ea]});
        end else begin
            sbq.push_back({2'b00, exp_hold});
        end
        if (ew) model[ea] = ed;
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk($sformatf("sbq_empty[v%0d]", id), 32'd0, 32'd1);
        end else begin
            r = sbq.pop_front();
            chk($sformatf("rvalid[v%0d]", id), 32'(rvalid), 32'(r.rv));
            chk($sformatf("rdata[v%0d]", id), 32'(rdata), 32'(r.rd));
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = 2'b11;
        we    = 2'b11;
        lock  = 2'b00;
        addr  = {8'h20, 8'h10};
        wdata = {8'h3C, 8'hA5};
        exp_hold = 8'h00;

        // idle / reset
        addv(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
        addv(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
        // write then read by requester 0, then requester 1 seeds two locations
        addv(2'b01, 2'b01, 2'b00, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01);
        addv(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01);
        addv(2'b10, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'h77, 2'b10);
        addv(2'b10, 2'b10, 2'b00, 8'h00, 8'h30, 8'h00, 8'h11, 2'b10);
        // round-robin fairness, all reads
        for (int i = 0; i < 6; i++)
            addv(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, (i % 2 == 0) ? 2'b01 : 2'b10);
        // read-after-write across requesters
        addv(2'b01, 2'b01, 2'b00, 8'h30, 8'h00, 8'h5E, 8'h00, 2'b01);
        addv(2'b10, 2'b00, 2'b00, 8'h00, 8'h30, 8'h00, 8'h00, 2'b10);
        addv(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01);
        // lock with forced release after 4 grants
        for (int i = 0; i < 4; i++)
            addv(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10);
        addv(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01);
        addv(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10);
        // owner drops req: no grant, back to round-robin
        addv(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00);
        addv(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01);
        addv(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10);
        // voluntary unlock after two locked cycles
        addv(2'b11, 2'b00, 2'b01, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01);
        addv(2'b11, 2'b00, 2'b01, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01);
        addv(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01);
        addv(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b10);

        // reset held with requests active: everything must stay quiet
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_mem_write_en", 32'(mem_write_en), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
            chk("rst_rvalid", 32'(rvalid), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
        end
        @(negedge clk);
        req   = 2'b00;
        we    = 2'b00;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // reset asserted mid-write by requester 1
        @(negedge clk);
        req   = 2'b10;
        we    = 2'b10;
        lock  = 2'b00;
        addr  = {8'h20, 8'h00};
        wdata = {8'h3C, 8'h00};
        #1;
        chk("mid_gnt_before", 32'(gnt), 32'h2);
        chk("mid_we_before", 32'(mem_write_en), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_we_after", 32'(mem_write_en), 32'd0);
        chk("mid_gnt_after", 32'(gnt), 32'd0);
        chk("mid_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rdata", 32'(rdata), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req   = 2'b00;
        we    = 2'b00;
        reset = 1'b1;
        exp_hold = 8'h00;
        #1;
        chk("post_rst_rdata", 32'(rdata), 32'd0);

        // requester 0 wins first again, then 0x20 still reads the old value
        vecs.delete();
        addv(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 8'h00, 8'h00, 2'b01);
        addv(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 8'h00, 8'h00, 2'b10);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 100 + i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
